// File: rtl/imem_fetch_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter_pkg
// Shared GPU parameters for the instruction-fetch path.
//   NUM_SIMD_CORES : number of SIMD cores sharing the IMEM read port
//   IMEM_LATENCY   : fixed cycles from IMEM address to read data
//   CORE_ID_W      : width of a core index
//   fetch_tag_t    : one in-flight fetch record {valid, core_id}
// ---------------------------------------------------------------------------
package imem_fetch_arbiter_pkg;

    localparam int NUM_SIMD_CORES = 4;
    localparam int IMEM_LATENCY   = 2;
    localparam int CORE_ID_W      = $clog2(NUM_SIMD_CORES);

    typedef struct packed {
        logic                 valid;
        logic [CORE_ID_W-1:0] core_id;
    } fetch_tag_t;

endpackage

// File: rtl/imem_fetch_arbiter_rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: selects the first asserted request when
// scanning from ptr_i upward, wrapping modulo N.
//   req_i    [N-1:0]    request vector
//   ptr_i    [ID_W-1:0] index with highest priority this cycle
//   gnt_o    [N-1:0]    one-hot grant (all zero when no request)
//   winner_o [ID_W-1:0] index of the granted requester (0 when none)
//   valid_o             any request granted
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] winner_o,
    output logic            valid_o
);

    always_comb begin
        int  idx;
        logic found;
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                gnt_o[idx]  = 1'b1;
                winner_o    = ID_W'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter
// Shares one IMEM read port among the SIMD cores. One round-robin grant per
// cycle drives the IMEM address; a tag shift pipeline of IMEM_LATENCY stages
// remembers which core each fetch belongs to so the returned word can be
// steered back. A per-core kill drops that core's in-flight fetches.
//   clk, rst                 clock, synchronous active-low reset
//   fetch_req [N-1:0]        per-core request (held until granted)
//   fetch_pc  [32*N-1:0]     per-core PC, core i in bits [32*i +: 32]
//   kill      [N-1:0]        per-core flush of in-flight fetches
//   fetch_gnt [N-1:0]        one-hot grant
//   imem_en, imem_addr       IMEM read strobe and address
//   imem_rdata               IMEM data, IMEM_LATENCY cycles after imem_en
//   resp_valid [N-1:0]       one-hot owner of resp_instr this cycle
//   resp_instr               returned instruction (broadcast)
//   busy                     any fetch in flight
// All outputs are held at zero while rst is low.
// ---------------------------------------------------------------------------
import imem_fetch_arbiter_pkg::*;

module imem_fetch_arbiter #(
    parameter int NUM_SIMD_CORES = imem_fetch_arbiter_pkg::NUM_SIMD_CORES,
    parameter int IMEM_LATENCY   = imem_fetch_arbiter_pkg::IMEM_LATENCY,
    parameter int CORE_ID_W      = $clog2(NUM_SIMD_CORES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SIMD_CORES-1:0]    fetch_req,
    input  logic [32*NUM_SIMD_CORES-1:0] fetch_pc,
    input  logic [NUM_SIMD_CORES-1:0]    kill,
    output logic [NUM_SIMD_CORES-1:0]    fetch_gnt,
    output logic                         imem_en,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic [NUM_SIMD_CORES-1:0]    resp_valid,
    output logic [31:0]                  resp_instr,
    output logic                         busy
);

    logic [CORE_ID_W-1:0]      ptr_q, ptr_d;
    logic [NUM_SIMD_CORES-1:0] eff_req;
    logic [NUM_SIMD_CORES-1:0] pick_gnt;
    logic [CORE_ID_W-1:0]      winner;
    logic                      pick_valid;

    logic [IMEM_LATENCY-1:0]                tag_valid_q, tag_valid_d;
    logic [IMEM_LATENCY-1:0][CORE_ID_W-1:0] tag_id_q, tag_id_d;
    // Stage valids after applying this cycle's kill vector.
    logic [IMEM_LATENCY-1:0]                tag_live;

    // A core being flushed must not start a new fetch in the same cycle.
    assign eff_req = fetch_req & ~kill;

    rr_priority_picker #(
        .N    (NUM_SIMD_CORES),
        .ID_W (CORE_ID_W)
    ) u_picker (
        .req_i    (eff_req),
        .ptr_i    (ptr_q),
        .gnt_o    (pick_gnt),
        .winner_o (winner),
        .valid_o  (pick_valid)
    );

    // Priority moves just past the winner; unchanged when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (pick_valid) begin
            ptr_d = CORE_ID_W'((int'(winner) + 1) % NUM_SIMD_CORES);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < IMEM_LATENCY; gi++) begin : g_stage
            assign tag_live[gi] = tag_valid_q[gi] & ~kill[tag_id_q[gi]];
            if (gi == 0) begin : g_head
                assign tag_valid_d[gi] = pick_valid;
                assign tag_id_d[gi]    = winner;
            end else begin : g_body
                assign tag_valid_d[gi] = tag_live[gi-1];
                assign tag_id_d[gi]    = tag_id_q[gi-1];
            end
        end

        for (gi = 0; gi < NUM_SIMD_CORES; gi++) begin : g_resp
            assign resp_valid[gi] = rst & tag_live[IMEM_LATENCY-1]
                                  & (tag_id_q[IMEM_LATENCY-1] == CORE_ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            tag_valid_q <= '0;
            tag_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign fetch_gnt  = rst ? pick_gnt : '0;
    assign imem_en    = rst & pick_valid;
    assign imem_addr  = imem_en ? fetch_pc[int'(winner)*32 +: 32] : 32'h0;
    assign resp_instr = (rst & tag_live[IMEM_LATENCY-1]) ? imem_rdata : 32'h0;
    assign busy       = rst & (|tag_valid_q);

endmodule
